// File: rtl/backprop_step_if.sv
// Handshake and data bundle between the derivative stage, backprop_step and its consumer.
// Combinational only. The bundle has no state and no latency of its own.
// The input side uses in_valid/in_ready and the output side uses out_valid/out_ready. Each vector packs element i at [i*data_size +: data_size].
interface backprop_step_if #(
    parameter int size      = 3,
    parameter int data_size = 16
);
    localparam int VW = size * data_size;

    logic          in_valid;
    logic          in_ready;
    logic [VW-1:0] diff_cost;
    logic [VW-1:0] diff_to_all;
    logic [VW-1:0] diff_start;
    logic [VW-1:0] diff_dense;
    logic          out_valid;
    logic          out_ready;
    logic [VW-1:0] delta_out;
    logic [VW-1:0] grad_out;
    logic [VW-1:0] err_out;

    // The upstream stage or the bench drives the inputs and consumes the results.
    modport master (
        output in_valid, diff_cost, diff_to_all, diff_start, diff_dense, out_ready,
        input  in_ready, out_valid, delta_out, grad_out, err_out
    );

    // The backprop_step side of the bundle.
    modport slave (
        input  in_valid, diff_cost, diff_to_all, diff_start, diff_dense, out_ready,
        output in_ready, out_valid, delta_out, grad_out, err_out
    );
endinterface

// File: rtl/backprop_step.sv
// Backward-pass step: per element, delta = cost*act', grad = delta*x and err = delta*w. One shared fixed-point multiplier computes all three.
// Latency: 3*size+1 cycles from the input handshake to out_valid, counting the handshake edge. The stage takes one vector set every 3*size+2 cycles.
// Backpressure: in_ready is high only in IDLE. Results stay on the outputs while out_valid is high and out_ready is low.
// Ports: clk and reset are a rising-edge clock and a synchronous active-high reset. bus is the slave modport carrying the input vectors, the results and both handshakes.
module backprop_step #(
    parameter int size      = 3,
    parameter int data_size = 16,
    parameter int frac_bits = 8
) (
    input  logic            clk,
    input  logic            reset,
    backprop_step_if.slave  bus
);
    localparam int DW = data_size;
    localparam int VW = size * data_size;
    localparam int IW = (size > 1) ? $clog2(size) : 1;

    // Saturation bounds expressed at full product width
    localparam logic signed [2*DW-1:0] SAT_MAX = {{(DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [2*DW-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [2:0] {IDLE, MUL_DELTA, MUL_GRAD, MUL_ERR, DONE} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [VW-1:0] cost_q, cost_d, act_q, act_d, start_q, start_d, dense_q, dense_d;
    logic [VW-1:0] delta_q, delta_d, grad_q, grad_d, err_q, err_d;

    logic signed [DW-1:0]   op_a, op_b;
    logic signed [2*DW-1:0] prod, shifted;
    logic        [DW-1:0]   fx_res;

    // The current state selects the operands of the single multiplier.
    // MUL_GRAD and MUL_ERR take delta from its register, so they use the saturated value.
    always_comb begin
        op_a = '0;
        op_b = '0;
        case (state_q)
            MUL_DELTA: begin
                op_a = cost_q[idx_q*DW +: DW];
                op_b = act_q[idx_q*DW +: DW];
            end
            MUL_GRAD: begin
                op_a = delta_q[idx_q*DW +: DW];
                op_b = start_q[idx_q*DW +: DW];
            end
            MUL_ERR: begin
                op_a = delta_q[idx_q*DW +: DW];
                op_b = dense_q[idx_q*DW +: DW];
            end
            default: ;
        endcase
    end

    // The arithmetic shift floors the quotient, so -1*1 gives -1 and not 0.
    assign prod    = op_a * op_b;
    assign shifted = prod >>> frac_bits;
    assign fx_res  = (shifted > SAT_MAX) ? SAT_MAX[DW-1:0] :
                     (shifted < SAT_MIN) ? SAT_MIN[DW-1:0] : shifted[DW-1:0];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cost_d  = cost_q;
        act_d   = act_q;
        start_d = start_q;
        dense_d = dense_q;
        delta_d = delta_q;
        grad_d  = grad_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    cost_d  = bus.diff_cost;
                    act_d   = bus.diff_to_all;
                    start_d = bus.diff_start;
                    dense_d = bus.diff_dense;
                    idx_d   = '0;
                    state_d = MUL_DELTA;
                end
            end
            MUL_DELTA: begin
                delta_d[idx_q*DW +: DW] = fx_res;
                state_d = MUL_GRAD;
            end
            MUL_GRAD: begin
                grad_d[idx_q*DW +: DW] = fx_res;
                state_d = MUL_ERR;
            end
            MUL_ERR: begin
                err_d[idx_q*DW +: DW] = fx_res;
                if (idx_q == IW'(size - 1)) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = MUL_DELTA;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cost_q  <= '0;
            act_q   <= '0;
            start_q <= '0;
            dense_q <= '0;
            delta_q <= '0;
            grad_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cost_q  <= cost_d;
            act_q   <= act_d;
            start_q <= start_d;
            dense_q <= dense_d;
            delta_q <= delta_d;
            grad_q  <= grad_d;
            err_q   <= err_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.delta_out = delta_q;
    assign bus.grad_out  = grad_q;
    assign bus.err_out   = err_q;
endmodule

// File: tb/tb_backprop_step.sv
// Bench for backprop_step. It drives random vector sets and compares the results against a plain-arithmetic model.
// It also checks the latency, stalls caused by consumer backpressure, and reset in the middle of an operation.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_backprop_step;
    localparam int N  = 3;
    localparam int DW = 16;
    localparam int VW = N * DW;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    backprop_step_if #(.size(N), .data_size(DW)) bus ();

    backprop_step #(.size(N), .data_size(DW), .frac_bits(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [3*VW-1:0] obs, input logic [3*VW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: exact product, floor division by 256, then clamp to the 16-bit range
    function automatic logic [DW-1:0] fx(input logic [DW-1:0] a, input logic [DW-1:0] b);
        longint p;
        longint q;
        p = longint'($signed(a)) * longint'($signed(b));
        q = p / 256;
        if (p < 0 && (p % 256) != 0) q = q - 1;
        if (q > 32767)  q = 32767;
        if (q < -32768) q = -32768;
        return q[DW-1:0];
    endfunction

    task automatic model(input logic [VW-1:0] c, input logic [VW-1:0] t, input logic [VW-1:0] s,
                         input logic [VW-1:0] d, output logic [VW-1:0] ed, output logic [VW-1:0] eg,
                         output logic [VW-1:0] ee);
        logic [DW-1:0] dl;
        for (int i = 0; i < N; i++) begin
            dl = fx(c[i*DW +: DW], t[i*DW +: DW]);
            ed[i*DW +: DW] = dl;
            eg[i*DW +: DW] = fx(dl, s[i*DW +: DW]);
            ee[i*DW +: DW] = fx(dl, d[i*DW +: DW]);
        end
    endtask

    function automatic logic [VW-1:0] rnd_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'($urandom);
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_inputs(input logic [VW-1:0] c, input logic [VW-1:0] t,
                                input logic [VW-1:0] s, input logic [VW-1:0] d);
        bus.diff_cost   = c;
        bus.diff_to_all = t;
        bus.diff_start  = s;
        bus.diff_dense  = d;
    endtask

    // Runs one full transaction. During the hold cycles out_ready stays low and stray in_valid pulses are offered.
    task automatic do_txn(input string tag, input logic [VW-1:0] c, input logic [VW-1:0] t,
                          input logic [VW-1:0] s, input logic [VW-1:0] d, input int hold,
                          output logic [3*VW-1:0] res);
        logic [VW-1:0] ed, eg, ee;
        int lat;
        model(c, t, s, d, ed, eg, ee);
        chk({tag, ".in_ready"}, 3*VW'(bus.in_ready), 3*VW'(1));
        drive_inputs(c, t, s, d);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        drive_inputs(rnd_vec(), rnd_vec(), rnd_vec(), rnd_vec());
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            bus.out_ready = 1'($urandom);
            step();
            lat++;
        end
        bus.out_ready = 1'b0;
        chk({tag, ".latency"}, 3*VW'(lat), 3*VW'(3*N+1));
        res = {bus.delta_out, bus.grad_out, bus.err_out};
        chk({tag, ".result"}, res, {ed, eg, ee});
        for (int k = 0; k < hold; k++) begin
            bus.in_valid = 1'b1;
            drive_inputs(rnd_vec(), rnd_vec(), rnd_vec(), rnd_vec());
            step();
            chk({tag, ".hold"}, {bus.delta_out, bus.grad_out, bus.err_out}, {ed, eg, ee});
            chk({tag, ".hold_hs"}, 3*VW'({bus.in_ready, bus.out_valid}), 3*VW'(2'b01));
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        chk({tag, ".release"}, 3*VW'({bus.in_ready, bus.out_valid}), 3*VW'(2'b10));
    endtask

    function automatic logic [VW-1:0] rep(input logic [DW-1:0] e);
        return {N{e}};
    endfunction

    initial begin
        logic [3*VW-1:0] res;
        logic [VW-1:0]   c, t, s, d;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive_inputs('0, '0, '0, '0);
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk("reset.hs", 3*VW'({bus.in_ready, bus.out_valid}), 3*VW'(2'b10));
        chk("reset.out", {bus.delta_out, bus.grad_out, bus.err_out}, '0);

        do_txn("basic", rep(16'h0200), rep(16'h0080), rep(16'h0300), rep(16'hFF00), 0, res);
        chk("basic.const", res, {rep(16'h0100), rep(16'h0300), rep(16'hFF00)});

        // Element 0 saturates high, element 1 saturates low, element 2 exercises floor truncation.
        c = {16'hFFFF, 16'h8000, 16'h7FFF};
        t = {16'h0001, 16'h7FFF, 16'h7FFF};
        s = {16'h0100, 16'h0200, 16'h0100};
        d = {16'h0300, 16'hFF00, 16'h0080};
        do_txn("sat", c, t, s, d, 1, res);
        chk("sat.delta", res[3*VW-1 -: VW], {16'hFFFF, 16'h8000, 16'h7FFF});
        chk("sat.grad_err", res[2*VW-1:0],
            {16'hFFFF, 16'h8000, 16'h7FFF, 16'hFFFD, 16'h7FFF, 16'h3FFF});

        do_txn("bp", rnd_vec(), rnd_vec(), rnd_vec(), rnd_vec(), 20, res);
        do_txn("bp_next", rep(16'h0100), {16'h0300, 16'h0200, 16'h0100}, rep(16'h0100),
               rep(16'h0100), 0, res);
        chk("bp_next.delta", res[3*VW-1 -: VW], {16'h0300, 16'h0200, 16'h0100});

        for (int r = 0; r < 20; r++) begin
            do_txn("rand", rnd_vec(), rnd_vec(), rnd_vec(), rnd_vec(), int'($urandom_range(0, 3)), res);
        end

        // Reset arrives while the multiplier is busy, four cycles after the input handshake.
        drive_inputs(rnd_vec(), rnd_vec(), rnd_vec(), rnd_vec());
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst.hs", 3*VW'({bus.in_ready, bus.out_valid}), 3*VW'(2'b10));
        chk("midrst.out", {bus.delta_out, bus.grad_out, bus.err_out}, '0);
        do_txn("midrst_next", rnd_vec(), rnd_vec(), rnd_vec(), rnd_vec(), 2, res);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
